// File: rtl/tmds_pkg.sv
// ---------------------------------------------------------------------------
// tmds_pkg
// Shared types, code-word tables and helpers for the TMDS symbol encoder.
//   tmds_mode_t  : per-pixel symbol mode
//   CTRL_CODES   : control-period code words indexed by {c1,c0}
//   VIDEO_GB     : video guard-band word indexed by channel
//   DATA_GB      : data-island guard-band word indexed by channel
//   TERC4_CODES  : 4b/10b data-island table
//   popcount8    : number of ones in a byte
// Build option: HDMI_TERC4_EN enables the data-island tables; without it
// the encoder is a DVI-only part and the TERC4 table is not present.
// Symbols are written tmds[9:0]; bit 0 goes on the wire first.
// ---------------------------------------------------------------------------
package tmds_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL     = 3'd0,
    MODE_VIDEO    = 3'd1,
    MODE_VIDEO_GB = 3'd2,
    MODE_DATA     = 3'd3,
    MODE_DATA_GB  = 3'd4
  } tmds_mode_t;

  localparam logic [9:0] CTRL_CODES [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  localparam logic [9:0] VIDEO_GB [3] = '{
    10'b1011001100,
    10'b0100110011,
    10'b1011001100
  };

`ifdef HDMI_TERC4_EN
  // Channel 0 carries TERC4 during the data-island guard band, so its
  // entry here is never selected; it is filled for table completeness.
  localparam logic [9:0] DATA_GB [3] = '{
    10'b0100110011,
    10'b0100110011,
    10'b0100110011
  };

  localparam logic [9:0] TERC4_CODES [16] = '{
    10'b1010011100,
    10'b1001100011,
    10'b1011100100,
    10'b1011100010,
    10'b0101110001,
    10'b0100011110,
    10'b0110001110,
    10'b0100111100,
    10'b1011001100,
    10'b0100111001,
    10'b0110011100,
    10'b1011000110,
    10'b1010001110,
    10'b1001110001,
    10'b0101100011,
    10'b1011000011
  };
`endif

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_disparity_stage.sv
// ---------------------------------------------------------------------------
// tmds_disparity_stage
// Second pipeline stage: picks the final 10-bit symbol and owns the running
// DC disparity counter (cnt). Video symbols steer cnt back toward zero;
// every non-video symbol clears it.
// Ports:
//   clk_pixel     in   pixel clock
//   reset         in   synchronous, active-high
//   mode          in   stage-1 mode (already folded to supported modes)
//   q_m           in   9-bit transition-minimised word from stage 1
//   n1q           in   ones count of q_m[7:0]
//   control_data  in   {c1,c0}
//   terc4_data    in   data-island nibble (HDMI_TERC4_EN builds only)
//   tmds          out  registered symbol, bit 0 first on the wire
// Build option: HDMI_TERC4_EN adds the data-island paths.
// ---------------------------------------------------------------------------
module tmds_disparity_stage
  import tmds_pkg::*;
#(
  parameter int CN = 0
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  tmds_mode_t mode,
  input  logic [8:0] q_m,
  input  logic [3:0] n1q,
  input  logic [1:0] control_data,
`ifdef HDMI_TERC4_EN
  input  logic [3:0] terc4_data,
`endif
  output logic [9:0] tmds
);

  localparam logic [9:0] VGB_SYM = VIDEO_GB[CN];
`ifdef HDMI_TERC4_EN
  localparam logic [9:0] DGB_SYM = DATA_GB[CN];
`endif

  logic signed [5:0] cnt;
  logic signed [5:0] cnt_nxt;
  logic signed [5:0] diff;
  logic [9:0]        sym;

  always_comb begin
    // diff = N1q - N0q = 2*N1q - 8
    diff    = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    sym     = CTRL_CODES[control_data];
    cnt_nxt = '0;
    case (mode)
      MODE_VIDEO: begin
        if (cnt == 6'sd0 || diff == 6'sd0) begin
          sym     = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
          cnt_nxt = q_m[8] ? (cnt + diff) : (cnt - diff);
        end else if ((cnt > 6'sd0 && diff > 6'sd0) ||
                     (cnt < 6'sd0 && diff < 6'sd0)) begin
          sym     = {1'b1, q_m[8], ~q_m[7:0]};
          cnt_nxt = cnt - diff + (q_m[8] ? 6'sd2 : 6'sd0);
        end else begin
          sym     = {1'b0, q_m[8], q_m[7:0]};
          cnt_nxt = cnt + diff - (q_m[8] ? 6'sd0 : 6'sd2);
        end
      end
      MODE_VIDEO_GB: sym = VGB_SYM;
`ifdef HDMI_TERC4_EN
      MODE_DATA:     sym = TERC4_CODES[terc4_data];
      MODE_DATA_GB:  sym = (CN == 0) ? TERC4_CODES[terc4_data] : DGB_SYM;
`endif
      default:       sym = CTRL_CODES[control_data];
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      tmds <= CTRL_CODES[0];
      cnt  <= '0;
    end else begin
      tmds <= sym;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/tmds_symbol_encoder.sv
// ---------------------------------------------------------------------------
// tmds_symbol_encoder
// Per-channel TMDS/HDMI symbol encoder, two-cycle fixed latency.
// Stage 1 does the 8b -> 9b transition-minimising step and the ones count;
// stage 2 (tmds_disparity_stage) does DC balancing and code selection.
// Ports:
//   clk_pixel     in   pixel clock, the only clock
//   reset         in   synchronous, active-high
//   mode          in   0 ctrl, 1 video, 2 video GB, 3 data, 4 data GB;
//                      5-7 encode as control
//   video_data    in   pixel component (mode 1)
//   control_data  in   {c1,c0} (mode 0)
//   terc4_data    in   data-island nibble (modes 3/4)
//   tmds          out  10-bit symbol, bit 0 transmitted first
// Parameter CN (0..2) selects the channel's guard-band words.
// Build option: HDMI_TERC4_EN. When undefined (DVI-only), modes 3 and 4
// encode as control and terc4_data is ignored.
// ---------------------------------------------------------------------------
module tmds_symbol_encoder
  import tmds_pkg::*;
#(
  parameter int CN = 0
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic [7:0] video_data,
  input  logic [1:0] control_data,
  input  logic [3:0] terc4_data,
  output logic [9:0] tmds
);

  tmds_mode_t mode_eff;
  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m;

  tmds_mode_t mode_s1;
  logic [8:0] q_m_s1;
  logic [3:0] n1q_s1;
  logic [1:0] ctrl_s1;

  // Unsupported modes are folded to control here so stage 2 only ever
  // sees codes it knows how to emit.
  always_comb begin
    mode_eff = MODE_CTRL;
    case (mode)
      3'd1:    mode_eff = MODE_VIDEO;
      3'd2:    mode_eff = MODE_VIDEO_GB;
`ifdef HDMI_TERC4_EN
      3'd3:    mode_eff = MODE_DATA;
      3'd4:    mode_eff = MODE_DATA_GB;
`endif
      default: mode_eff = MODE_CTRL;
    endcase
  end

  always_comb begin
    logic prev;
    logic cur;
    n1d      = popcount8(video_data);
    use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !video_data[0]);
    q_m      = '0;
    q_m[0]   = video_data[0];
    prev     = video_data[0];
    for (int i = 1; i < 8; i++) begin
      cur    = use_xnor ? ~(prev ^ video_data[i]) : (prev ^ video_data[i]);
      q_m[i] = cur;
      prev   = cur;
    end
    q_m[8]   = ~use_xnor;
  end

`ifdef HDMI_TERC4_EN
  logic [3:0] terc4_s1;
`else
  logic [3:0] unused_terc4;
  assign unused_terc4 = terc4_data;
`endif

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      mode_s1  <= MODE_CTRL;
      q_m_s1   <= '0;
      n1q_s1   <= '0;
      ctrl_s1  <= '0;
`ifdef HDMI_TERC4_EN
      terc4_s1 <= '0;
`endif
    end else begin
      mode_s1  <= mode_eff;
      q_m_s1   <= q_m;
      n1q_s1   <= popcount8(q_m[7:0]);
      ctrl_s1  <= control_data;
`ifdef HDMI_TERC4_EN
      terc4_s1 <= terc4_data;
`endif
    end
  end

  tmds_disparity_stage #(
    .CN(CN)
  ) u_disparity (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .mode         (mode_s1),
    .q_m          (q_m_s1),
    .n1q          (n1q_s1),
    .control_data (ctrl_s1),
`ifdef HDMI_TERC4_EN
    .terc4_data   (terc4_s1),
`endif
    .tmds         (tmds)
  );

endmodule

// File: tb/tb_tmds_symbol_encoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_symbol_encoder
// Drives one stimulus stream into all three channels (CN = 0, 1, 2).
// A reference model predicts each channel's symbol two edges after the
// inputs are sampled; the running disparity is tracked as the cumulative
// (ones - zeros) of emitted video symbols since the last non-video symbol.
// Video symbols are also decoded back to the pixel byte.
// ---------------------------------------------------------------------------
module tb_tmds_symbol_encoder;

  localparam logic [9:0] CTRL_TAB [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };
  localparam logic [9:0] TERC4_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  localparam logic [9:0] VGB_A = 10'b1011001100;
  localparam logic [9:0] GB_B  = 10'b0100110011;

  typedef struct packed {
    logic       rst;
    logic [2:0] mode;
    logic [7:0] vd;
    logic [1:0] cd;
    logic [3:0] t4;
  } sample_t;

  logic       clk_pixel = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] mode = 3'd0;
  logic [7:0] video_data = 8'd0;
  logic [1:0] control_data = 2'd0;
  logic [3:0] terc4_data = 4'd0;
  logic [9:0] tmds_out [3];

  always #5 clk_pixel = ~clk_pixel;

  tmds_symbol_encoder #(.CN(0)) dut0 (
    .clk_pixel(clk_pixel), .reset(reset), .mode(mode), .video_data(video_data),
    .control_data(control_data), .terc4_data(terc4_data), .tmds(tmds_out[0]));
  tmds_symbol_encoder #(.CN(1)) dut1 (
    .clk_pixel(clk_pixel), .reset(reset), .mode(mode), .video_data(video_data),
    .control_data(control_data), .terc4_data(terc4_data), .tmds(tmds_out[1]));
  tmds_symbol_encoder #(.CN(2)) dut2 (
    .clk_pixel(clk_pixel), .reset(reset), .mode(mode), .video_data(video_data),
    .control_data(control_data), .terc4_data(terc4_data), .tmds(tmds_out[2]));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int ch, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s ch%0d got %0d want %0d at %0t", name, ch, got, want, $time);
    end
  endtask

  function automatic int dut_cnt(input int ch);
    case (ch)
      0:       return int'(dut0.u_disparity.cnt);
      1:       return int'(dut1.u_disparity.cnt);
      default: return int'(dut2.u_disparity.cnt);
    endcase
  endfunction

  function automatic int eff_mode(input logic [2:0] m);
    if (m > 3'd4) return 0;
`ifndef HDMI_TERC4_EN
    if (m == 3'd3 || m == 3'd4) return 0;
`endif
    return int'(m);
  endfunction

  function automatic logic [9:0] ref_video(input logic [7:0] d, input int cnt);
    int         n1d;
    int         n1q;
    int         n0q;
    bit         xn;
    logic [8:0] q;
    n1d  = $countones(d);
    xn   = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    n1q  = $countones(q[7:0]);
    n0q  = 8 - n1q;
    if (cnt == 0 || n1q == n0q)
      return {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
    if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q))
      return {1'b1, q[8], ~q[7:0]};
    return {1'b0, q[8], q[7:0]};
  endfunction

  function automatic logic [7:0] decode_video(input logic [9:0] s);
    logic [7:0] x;
    logic [7:0] d;
    x    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = x[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] model_sym(input int cn, input sample_t s, input int cnt);
    case (eff_mode(s.mode))
      1:       return ref_video(s.vd, cnt);
      2:       return (cn == 1) ? GB_B : VGB_A;
      3:       return TERC4_TAB[s.t4];
      4:       return (cn == 0) ? TERC4_TAB[s.t4] : GB_B;
      default: return CTRL_TAB[s.cd];
    endcase
  endfunction

  // ---- compare process: runs every cycle once reset has been seen ----
  sample_t    pipe [$];
  sample_t    now_s;
  sample_t    due;
  bit         primed = 1'b0;
  int         mcnt [3];
  logic [9:0] exp_sym;
  int         dc;

  always @(posedge clk_pixel) begin
    now_s = '{reset, mode, video_data, control_data, terc4_data};
    #1;
    if (now_s.rst) begin
      pipe.delete();
      pipe.push_back('{1'b0, 3'd0, 8'd0, 2'd0, 4'd0});
      primed = 1'b1;
      for (int ch = 0; ch < 3; ch++) begin
        mcnt[ch] = 0;
        check("reset_sym", ch, int'(tmds_out[ch]), int'(CTRL_TAB[0]));
        check("reset_cnt", ch, dut_cnt(ch), 0);
      end
    end else if (primed) begin
      due = pipe.pop_front();
      pipe.push_back(now_s);
      for (int ch = 0; ch < 3; ch++) begin
        exp_sym = model_sym(ch, due, mcnt[ch]);
        if (eff_mode(due.mode) == 1)
          mcnt[ch] = mcnt[ch] + 2 * $countones(exp_sym) - 10;
        else
          mcnt[ch] = 0;
        check("symbol", ch, int'(tmds_out[ch]), int'(exp_sym));
        dc = dut_cnt(ch);
        check("disparity", ch, dc, mcnt[ch]);
        if (eff_mode(due.mode) == 1) begin
          check("decode", ch, int'(decode_video(tmds_out[ch])), int'(due.vd));
          check("cnt_bound", ch, int'(dc <= 10 && dc >= -10), 1);
        end
      end
    end
  end

  // ---- stimulus ----
  task automatic drive(input logic r, input logic [2:0] m, input logic [7:0] v,
                       input logic [1:0] c, input logic [3:0] t);
    @(negedge clk_pixel);
    reset        = r;
    mode         = m;
    video_data   = v;
    control_data = c;
    terc4_data   = t;
  endtask

  int burst = 0;
  int r;

  initial begin
    // reset held, then released: control 00 throughout the flush
    repeat (3) begin
      @(negedge clk_pixel);
      check("lit_rst_hold", 0, int'(tmds_out[0]), int'(10'b1101010100));
    end
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
    check("lit_rst_rel0", 0, int'(tmds_out[0]), int'(10'b1101010100));
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
    check("lit_rst_rel1", 0, int'(tmds_out[0]), int'(10'b1101010100));
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
    check("lit_rst_rel2", 0, int'(tmds_out[0]), int'(10'b1101010100));

    // three zero pixels from cnt 0
    drive(0, 3'd1, 8'h00, 2'd0, 4'd0);
    drive(0, 3'd1, 8'h00, 2'd0, 4'd0);
    drive(0, 3'd1, 8'h00, 2'd0, 4'd0);
    check("lit_v0_sym", 0, int'(tmds_out[0]), 'h100);
    check("lit_v0_cnt", 0, dut_cnt(0), -8);
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
    check("lit_v1_sym", 1, int'(tmds_out[1]), 'h3FF);
    check("lit_v1_cnt", 1, dut_cnt(1), 2);
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
    check("lit_v2_sym", 2, int'(tmds_out[2]), 'h100);
    check("lit_v2_cnt", 2, dut_cnt(2), -6);

    // control sweep
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
    drive(0, 3'd0, 8'h00, 2'd1, 4'd0);
    drive(0, 3'd0, 8'h00, 2'd2, 4'd0);
    check("lit_c00", 0, int'(tmds_out[0]), int'(10'b1101010100));
    drive(0, 3'd0, 8'h00, 2'd3, 4'd0);
    check("lit_c01", 0, int'(tmds_out[0]), int'(10'b0010101011));
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
    check("lit_c10", 0, int'(tmds_out[0]), int'(10'b0101010100));
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
    check("lit_c11", 0, int'(tmds_out[0]), int'(10'b1010101011));
    check("lit_c_cnt", 0, dut_cnt(0), 0);

    // guard bands
    drive(0, 3'd2, 8'h5A, 2'd0, 4'd0);
    drive(0, 3'd4, 8'h5A, 2'd0, 4'd0);
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
    check("lit_vgb_cn0", 0, int'(tmds_out[0]), int'(10'b1011001100));
    check("lit_vgb_cn1", 1, int'(tmds_out[1]), int'(10'b0100110011));
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
`ifdef HDMI_TERC4_EN
    check("lit_dgb_cn0", 0, int'(tmds_out[0]), int'(10'b1010011100));
    check("lit_dgb_cn1", 1, int'(tmds_out[1]), int'(10'b0100110011));
`else
    check("lit_dgb_cn0", 0, int'(tmds_out[0]), int'(10'b1101010100));
    check("lit_dgb_cn1", 1, int'(tmds_out[1]), int'(10'b1101010100));
`endif

    // data island symbol
    drive(0, 3'd3, 8'h00, 2'd2, 4'd5);
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
    drive(0, 3'd0, 8'h00, 2'd0, 4'd0);
`ifdef HDMI_TERC4_EN
    check("lit_data", 2, int'(tmds_out[2]), int'(10'b0100011110));
`else
    check("lit_data", 2, int'(tmds_out[2]), int'(10'b0101010100));
`endif

    // randomized traffic: mostly video, control bursts, stray modes,
    // one reset in the middle of the stream
    for (int i = 0; i < 10000; i++) begin
      r = int'($urandom_range(0, 99));
      if (i == 5000) begin
        drive(1, 3'd1, 8'($urandom), 2'($urandom), 4'($urandom));
        drive(1, 3'd1, 8'($urandom), 2'($urandom), 4'($urandom));
      end else if (burst > 0) begin
        burst--;
        drive(0, 3'd0, 8'($urandom), 2'($urandom), 4'($urandom));
      end else if (r < 4) begin
        burst = int'($urandom_range(1, 6));
        drive(0, 3'd0, 8'($urandom), 2'($urandom), 4'($urandom));
      end else if (r < 10) begin
        drive(0, 3'($urandom), 8'($urandom), 2'($urandom), 4'($urandom));
      end else begin
        drive(0, 3'd1, 8'($urandom), 2'($urandom), 4'($urandom));
      end
    end
    repeat (4) drive(0, 3'd0, 8'h00, 2'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
